alu_issue_controller: RTL and testbench



---
 rtl/alu_issue_controller_if.sv | 45 ++++
 rtl/alu_issue_controller.sv | 175 +++++++++++++++++
 tb/tb_alu_issue_controller.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_controller_if.sv
// Instruction intake, issue, writeback and status bundle for alu_issue_controller.
// The master side is the fetch/testbench driver; the slave side is the controller.
interface alu_issue_controller_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic        flush;
    logic        fault_clear;

    logic        issue_valid;
    logic [2:0]  issue_op;
    logic        issue_form;
    logic [1:0]  issue_vec_perci;
    logic        issue_const;
    logic [31:0] issue_constant;
    logic [3:0]  issue_a_sel;
    logic [3:0]  issue_b_sel;
    logic [3:0]  issue_c_sel;
    logic [3:0]  issue_d_sel;

    logic [1:0]  wb_valid;
    logic [3:0]  wb_y1_sel;
    logic [3:0]  wb_y2_sel;

    logic [15:0] busy_mask;
    logic        fault;
    logic [31:0] fault_instruction;
    logic        idle;

    modport master (
        output in_valid, in_instruction, flush, fault_clear,
        input  in_ready, issue_valid, issue_op, issue_form, issue_vec_perci,
               issue_const, issue_constant, issue_a_sel, issue_b_sel,
               issue_c_sel, issue_d_sel, wb_valid, wb_y1_sel, wb_y2_sel,
               busy_mask, fault, fault_instruction, idle
    );

    modport slave (
        input  in_valid, in_instruction, flush, fault_clear,
        output in_ready, issue_valid, issue_op, issue_form, issue_vec_perci,
               issue_const, issue_constant, issue_a_sel, issue_b_sel,
               issue_c_sel, issue_d_sel, wb_valid, wb_y1_sel, wb_y2_sel,
               busy_mask, fault, fault_instruction, idle
    );
endinterface

// File: rtl/alu_issue_controller.sv
// ALU issue sequencer: decodes instructions, blocks on a 16-entry register scoreboard,
// issues hazard-free ops and retires their register writes ALU_LATENCY cycles later.
module alu_issue_controller #(
    parameter int ALU_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_issue_controller_if.slave bus
);
    localparam int STAGES = ALU_LATENCY;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    typedef struct packed {
        logic       y1_we;
        logic       y2_we;
        logic [3:0] y1_sel;
        logic [3:0] y2_sel;
    } wb_entry_t;

    state_t                   state;
    logic [15:0]              busy;
    logic [STAGES:0]          vld_pipe;
    wb_entry_t [STAGES:0]     wb_pipe;

    logic                     issue_valid_q;
    logic [2:0]               issue_op_q;
    logic                     issue_form_q;
    logic [1:0]               issue_vec_q;
    logic                     issue_const_q;
    logic [31:0]              issue_constant_q;
    logic [3:0]               a_q, b_q, c_q, d_q;
    logic                     fault_q;
    logic [31:0]              fault_instr_q;

    logic                     c_const, c_form, c_invalid;
    logic [3:0]               sel_a, sel_b, sel_c, sel_d;
    logic [15:0]              src_mask, dst_mask, clear_mask, release_busy;
    logic                     hazard, ready, accept, do_issue, do_trap;
    wb_entry_t                new_entry;
    logic                     new_vld;

    assign c_const   = bus.in_instruction[28];
    assign c_form    = bus.in_instruction[24];
    assign c_invalid = c_const & c_form;
    assign sel_a     = bus.in_instruction[15:12];
    assign sel_b     = bus.in_instruction[11:8];
    assign sel_c     = bus.in_instruction[7:4];
    assign sel_d     = bus.in_instruction[3:0];

    // Register 0 is hardwired zero: never a source hazard, never a destination.
    always_comb begin
        src_mask = '0;
        dst_mask = '0;
        if (!c_const) begin
            src_mask[sel_a] = 1'b1;
            src_mask[sel_b] = 1'b1;
            src_mask[sel_c] = 1'b1;
            src_mask[sel_d] = 1'b1;
            dst_mask[sel_a] = 1'b1;
            dst_mask[sel_c] = 1'b1;
        end else if (!c_form) begin
            dst_mask[sel_a] = 1'b1;
        end
        src_mask[0] = 1'b0;
        dst_mask[0] = 1'b0;
    end

    always_comb begin
        clear_mask = '0;
        if (vld_pipe[STAGES] && wb_pipe[STAGES].y1_we) clear_mask[wb_pipe[STAGES].y1_sel] = 1'b1;
        if (vld_pipe[STAGES] && wb_pipe[STAGES].y2_we) clear_mask[wb_pipe[STAGES].y2_sel] = 1'b1;
    end

    // Registers retiring this cycle are already free for the next instruction.
    assign release_busy = busy & ~clear_mask;
    assign hazard       = ~c_invalid & (|((src_mask | dst_mask) & release_busy));
    assign ready        = (state == RUN) & ~bus.flush & ~hazard;
    assign accept       = bus.in_valid & ready;
    assign do_issue     = accept & ~c_invalid;
    assign do_trap      = accept & c_invalid;

    always_comb begin
        new_entry        = '0;
        new_entry.y1_we  = do_issue & (sel_a != 4'd0);
        new_entry.y1_sel = sel_a;
        new_entry.y2_we  = do_issue & ~c_const & (sel_c != 4'd0);
        new_entry.y2_sel = c_const ? 4'd0 : sel_c;
        if (!do_issue) new_entry = '0;
        new_vld = new_entry.y1_we | new_entry.y2_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RUN;
            busy             <= '0;
            vld_pipe         <= '0;
            wb_pipe          <= '0;
            issue_valid_q    <= 1'b0;
            issue_op_q       <= '0;
            issue_form_q     <= 1'b0;
            issue_vec_q      <= '0;
            issue_const_q    <= 1'b0;
            issue_constant_q <= '0;
            a_q              <= '0;
            b_q              <= '0;
            c_q              <= '0;
            d_q              <= '0;
            fault_q          <= 1'b0;
            fault_instr_q    <= '0;
        end else begin
            issue_valid_q <= do_issue;
            if (do_issue) begin
                issue_op_q       <= bus.in_instruction[27:25];
                issue_form_q     <= c_form;
                issue_vec_q      <= bus.in_instruction[23:22];
                issue_const_q    <= c_const;
                issue_constant_q <= (c_const && !c_form) ?
                                    {14'b0, bus.in_instruction[21:16], bus.in_instruction[11:0]} : 32'd0;
                a_q              <= sel_a;
                b_q              <= sel_b;
                c_q              <= sel_c;
                d_q              <= sel_d;
            end

            // A new reservation overrides a retirement of the same register.
            busy <= release_busy | (do_issue ? dst_mask : 16'd0);

            vld_pipe   <= {vld_pipe[STAGES-1:0], new_vld};
            wb_pipe[0] <= new_entry;
            for (int i = 1; i <= STAGES; i++) wb_pipe[i] <= wb_pipe[i-1];

            case (state)
                RUN: begin
                    if (bus.flush) begin
                        state <= DRAIN;
                    end else if (do_trap) begin
                        state         <= HALT;
                        fault_q       <= 1'b1;
                        fault_instr_q <= bus.in_instruction;
                    end
                end
                DRAIN: begin
                    if (!bus.flush && busy == 16'd0 && vld_pipe == '0) state <= RUN;
                end
                HALT: begin
                    if (bus.fault_clear) begin
                        state   <= RUN;
                        fault_q <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.in_ready          = ready;
    assign bus.issue_valid       = issue_valid_q;
    assign bus.issue_op          = issue_op_q;
    assign bus.issue_form        = issue_form_q;
    assign bus.issue_vec_perci   = issue_vec_q;
    assign bus.issue_const       = issue_const_q;
    assign bus.issue_constant    = issue_constant_q;
    assign bus.issue_a_sel       = a_q;
    assign bus.issue_b_sel       = b_q;
    assign bus.issue_c_sel       = c_q;
    assign bus.issue_d_sel       = d_q;
    assign bus.wb_valid          = vld_pipe[STAGES] ? {wb_pipe[STAGES].y2_we, wb_pipe[STAGES].y1_we} : 2'b00;
    assign bus.wb_y1_sel         = wb_pipe[STAGES].y1_sel;
    assign bus.wb_y2_sel         = wb_pipe[STAGES].y2_sel;
    assign bus.busy_mask         = busy;
    assign bus.fault             = fault_q;
    assign bus.fault_instruction = fault_instr_q;
    assign bus.idle              = (state == RUN) && (busy == 16'd0) && (vld_pipe == '0);
endmodule

// File: tb/tb_alu_issue_controller.sv
// Randomized scoreboard bench for alu_issue_controller against a cycle-level model
// that tracks, per register, the cycle in which its pending write retires.
module tb_alu_issue_controller;
    localparam int L = 2;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_controller_if bus();
    alu_issue_controller #(.ALU_LATENCY(L)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int          cyc;
        logic [22:0] fields;   // {op, form, vec, const, a, b, c, d}
        logic [31:0] k;
    } iss_t;

    typedef struct {
        int         cyc;
        logic [1:0] we;
        logic [3:0] y1;
        logic [3:0] y2;
    } wb_t;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    iss_t        iq[$];
    wb_t         wq[$];
    int          wbcyc[16];      // cycle in which the latest write to r retires
    int          mode;
    logic [31:0] m_finstr;
    bit          clr_pending;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit hz(input logic [3:0] r, input int t);
        return (r != 4'd0) && (wbcyc[r] > t);
    endfunction

    task automatic model_clear();
        iq.delete();
        wq.delete();
        foreach (wbcyc[i]) wbcyc[i] = -1;
        mode     = M_RUN;
        m_finstr = '0;
    endtask

    // One clock cycle: drive, predict, check per-cycle status, advance the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                        input logic fc, input logic rs);
        logic        cst, frm, inv, haz, rdy, acc;
        logic [3:0]  a, b, c, d;
        logic [15:0] bm;
        iss_t        ie;
        wb_t         we;
        @(posedge clk);
        #1;
        if (clr_pending) begin
            model_clear();
            clr_pending = 0;
        end
        bus.in_valid       = v;
        bus.in_instruction = ins;
        bus.flush          = fl;
        bus.fault_clear    = fc;
        reset              = rs;

        cst = ins[28];
        frm = ins[24];
        inv = cst & frm;
        a = ins[15:12]; b = ins[11:8]; c = ins[7:4]; d = ins[3:0];
        bm = '0;
        for (int r = 1; r < 16; r++) if (wbcyc[r] >= cyc) bm[r] = 1'b1;
        haz = 1'b0;
        if (!cst) haz = hz(a, cyc) | hz(b, cyc) | hz(c, cyc) | hz(d, cyc);
        else if (!frm) haz = hz(a, cyc);
        rdy = (mode == M_RUN) && !fl && !haz;
        acc = v && rdy && !rs;

        @(negedge clk);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
        chk("busy_mask", {16'd0, bus.busy_mask}, {16'd0, bm});
        chk("fault", {31'd0, bus.fault}, {31'd0, mode == M_HALT});
        chk("fault_instruction", bus.fault_instruction, m_finstr);
        chk("idle", {31'd0, bus.idle}, {31'd0, (mode == M_RUN) && (bm == 16'd0)});

        if (rs) begin
            clr_pending = 1;
        end else begin
            if (acc && !inv) begin
                ie.cyc    = cyc + 1;
                ie.fields = {ins[27:25], ins[24], ins[23:22], ins[28], a, b, c, d};
                ie.k      = cst ? {14'd0, ins[21:16], ins[11:0]} : 32'd0;
                iq.push_back(ie);
                we.cyc = cyc + 1 + L;
                we.we  = {(!cst && c != 4'd0), (a != 4'd0)};
                we.y1  = a;
                we.y2  = cst ? 4'd0 : c;
                if (we.we != 2'b00) wq.push_back(we);
                if (a != 4'd0) wbcyc[a] = cyc + 1 + L;
                if (!cst && c != 4'd0) wbcyc[c] = cyc + 1 + L;
            end
            case (mode)
                M_RUN: begin
                    if (fl) mode = M_DRAIN;
                    else if (acc && inv) begin
                        mode     = M_HALT;
                        m_finstr = ins;
                    end
                end
                M_DRAIN: if (!fl && bm == 16'd0) mode = M_RUN;
                default: if (fc) mode = M_RUN;
            endcase
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] x;
        x = $urandom;
        x[15:12] = 4'($urandom % 6);
        x[11:8]  = 4'($urandom % 6);
        x[7:4]   = 4'($urandom % 6);
        x[3:0]   = 4'($urandom % 6);
        x[28]    = ($urandom % 4 == 0);
        if (x[28] && x[24] && ($urandom % 3 != 0)) x[24] = 1'b0;
        return x;
    endfunction

    // Monitor: pops expected issue/writeback events whenever the DUT presents them.
    initial begin
        iss_t ie;
        wb_t  we;
        logic [9:0] act, exp;
        forever begin
            @(negedge clk);
            if (bus.issue_valid) begin
                if (iq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL issue_unexpected cyc=%0d got issue_valid=1 expected none", cyc);
                end else begin
                    ie = iq.pop_front();
                    chk("issue_cycle", cyc, ie.cyc);
                    chk("issue_fields", {9'd0, bus.issue_op, bus.issue_form, bus.issue_vec_perci,
                        bus.issue_const, bus.issue_a_sel, bus.issue_b_sel, bus.issue_c_sel,
                        bus.issue_d_sel}, {9'd0, ie.fields});
                    chk("issue_constant", bus.issue_constant, ie.k);
                end
            end else if (iq.size() != 0 && iq[0].cyc <= cyc) begin
                ie = iq.pop_front();
                vectors++; miscompares++;
                $display("FAIL issue_missing cyc=%0d got issue_valid=0 expected issue for cyc %0d", cyc, ie.cyc);
            end

            if (bus.wb_valid != 2'b00) begin
                if (wq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL wb_unexpected cyc=%0d got wb_valid=%b expected none", cyc, bus.wb_valid);
                end else begin
                    we = wq.pop_front();
                    act = {bus.wb_valid, bus.wb_valid[0] ? bus.wb_y1_sel : 4'h0,
                           bus.wb_valid[1] ? bus.wb_y2_sel : 4'h0};
                    exp = {we.we, we.we[0] ? we.y1 : 4'h0, we.we[1] ? we.y2 : 4'h0};
                    chk("wb_cycle", cyc, we.cyc);
                    chk("wb_strobe_sel", {22'd0, act}, {22'd0, exp});
                end
            end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
                we = wq.pop_front();
                vectors++; miscompares++;
                $display("FAIL wb_missing cyc=%0d got wb_valid=00 expected %b for cyc %0d", cyc, we.we, we.cyc);
            end
        end
    end

    initial begin
        reset              = 1'b1;
        bus.in_valid       = 1'b0;
        bus.in_instruction = '0;
        bus.flush          = 1'b0;
        bus.fault_clear    = 1'b0;
        clr_pending        = 0;
        model_clear();
        repeat (3) @(posedge clk);

        // Basic issue then RAW hazard released by same-cycle writeback
        step(1, 32'h02001234, 0, 0, 0);
        repeat (3) step(1, 32'h02005100, 0, 0, 0);
        repeat (4) step(0, 32'h0, 0, 0, 0);
        // Constant form and zero register
        step(1, 32'h10055ABC, 0, 0, 0);
        repeat (4) step(0, 32'h0, 0, 0, 0);
        step(1, 32'h02000000, 0, 0, 0);
        step(1, 32'h02000000, 0, 0, 0);
        repeat (4) step(0, 32'h0, 0, 0, 0);
        // Trap with an older write still in flight, then clear
        step(1, 32'h02001234, 0, 0, 0);
        step(1, 32'h11000000, 0, 0, 0);
        repeat (4) step(1, 32'h02006789, 0, 0, 0);
        step(0, 32'h0, 0, 1, 0);
        step(1, 32'h02006789, 0, 0, 0);
        repeat (4) step(0, 32'h0, 0, 0, 0);
        // Flush one cycle after an accept
        step(1, 32'h02001234, 0, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        repeat (5) step(1, 32'h02000000, 0, 0, 0);
        repeat (4) step(0, 32'h0, 0, 0, 0);
        // Reset while a write is in flight
        step(1, 32'h02001234, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 1);
        repeat (4) step(0, 32'h0, 0, 0, 0);

        for (int n = 0; n < 4000; n++)
            step(($urandom % 4) != 0, rnd_instr(), ($urandom % 40) == 0,
                 ($urandom % 4) == 0, ($urandom % 300) == 0);

        repeat (L + 4) step(0, 32'h0, 0, 1, 0);
        if (iq.size() != 0 || wq.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_leftover got %0d issue/%0d wb events outstanding expected 0/0", iq.size(), wq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
